// File: rtl/fetch_unit_pkg.sv
// Shared constants and the redirect-cause type for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned DEFAULT_RESET_VEC  = 32;
  localparam int unsigned DEFAULT_INT_VEC    = 0;
  localparam logic [3:0]  DEFAULT_IMM_OPCODE = 4'd8;

  typedef enum logic [2:0] {
    NONE,
    EXC,
    INT,
    POP,
    JMP
  } redirect_e;

  // Fixed priority: exception, pending interrupt, return, jump.
  function automatic redirect_e selectRedirect(input logic exc, input logic intPend,
                                               input logic pop, input logic jmp);
    if (exc)     return EXC;
    if (intPend) return INT;
    if (pop)     return POP;
    if (jmp)     return JMP;
    return NONE;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus and decode handshake bundles used by the fetch unit.
interface fetch_imem_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 16
);
  logic               rd;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] data;

  modport master (output rd, output addr, input data);
  modport slave  (input rd, input addr, output data);
endinterface

interface fetch_dec_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 16
);
  logic               valid;
  logic               ready;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] imm;
  logic               hasImm;
  logic [ADDR_W-1:0]  pc;
  logic               isInt;

  modport master (output valid, output instr, output imm, output hasImm,
                  output pc, output isInt, input ready);
  modport slave  (input valid, input instr, input imm, input hasImm,
                  input pc, input isInt, output ready);
endinterface

// File: rtl/fetch_unit_word_fifo.sv
// Word queue with a two-entry read port so a two-word instruction pops in one cycle.
module fetch_word_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             pushData_i,
  input  logic                         pop_i,
  input  logic                         popTwo_i,
  output logic [WIDTH-1:0]             head0_o,
  output logic [WIDTH-1:0]             head1_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       popNum;
  logic             pushOk;

  // Pops beyond the stored words and pushes into a full queue are ignored.
  always_comb begin
    popNum = 2'd0;
    if (pop_i) popNum = popTwo_i ? 2'd2 : 2'd1;
    if (CNT_W'(popNum) > count_q) popNum = 2'd0;
    pushOk = push_i && !flush_i && ((count_q - CNT_W'(popNum)) < CNT_W'(DEPTH));
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      rdPtr_d = rdPtr_q + PTR_W'(popNum);
      wrPtr_d = wrPtr_q + PTR_W'(pushOk);
      count_d = count_q + CNT_W'(pushOk) - CNT_W'(popNum);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushOk && !reset_i) mem_q[wrPtr_q] <= pushData_i;
  end

  assign head0_o = mem_q[rdPtr_q];
  assign head1_o = mem_q[rdPtr_q + PTR_W'(1)];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, redirects, word queue and one/two-word decode hand-off.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          INSTR_W    = 16,
  parameter int          QDEPTH     = 4,
  parameter int unsigned RESET_VEC  = DEFAULT_RESET_VEC,
  parameter int unsigned INT_VEC    = DEFAULT_INT_VEC,
  parameter logic [3:0]  IMM_OPCODE = DEFAULT_IMM_OPCODE
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  fetch_imem_if.master                  imem,
  input  logic                          interrupt_i,
  input  logic                          exception_i,
  input  logic                          pop_pc_i,
  input  logic [ADDR_W-1:0]             pc_pop_value_i,
  input  logic                          jmp_sgn_i,
  input  logic [ADDR_W-1:0]             pc_jmp_value_i,
  fetch_dec_if.master                   dec,
  output logic [$clog2(QDEPTH+1)-1:0]   q_count_o
);

  localparam int CNT_W   = $clog2(QDEPTH+1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d, inflightAddr_q, redirectTarget;
  logic               inflight_q, intPrev_q, intPending_q, intPending_d, intFlag_q, intFlag_d;
  logic [INSTR_W-1:0] heldInstr_q, heldImm_q;
  logic [ADDR_W-1:0]  heldPc_q;
  logic               heldHasImm_q, heldInt_q;
  redirect_e          cause;
  logic               redirect, fetchOk, decValid, fire, headIsImm, haveWords;
  logic [ENTRY_W-1:0] head0, head1;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;
  logic [INSTR_W-1:0] curImm;
  logic [ADDR_W-1:0]  curPc;

  assign cause    = selectRedirect(exception_i, intPending_q, pop_pc_i, jmp_sgn_i);
  assign redirect = (cause != NONE);

  always_comb begin
    case (cause)
      EXC:     redirectTarget = ADDR_W'(RESET_VEC);
      INT:     redirectTarget = ADDR_W'(INT_VEC);
      POP:     redirectTarget = pc_pop_value_i;
      JMP:     redirectTarget = pc_jmp_value_i;
      default: redirectTarget = pc_q;
    endcase
  end

  // A request is only issued when its response is guaranteed a queue slot.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q);
  assign fetchOk   = !reset_i && !redirect && (occupancy < (CNT_W+1)'(QDEPTH));

  assign headIsImm = (head0[INSTR_W-1 -: 4] == IMM_OPCODE);
  assign haveWords = headIsImm ? (count >= CNT_W'(2)) : (count >= CNT_W'(1));
  assign decValid  = !reset_i && !redirect && haveWords;
  assign fire      = decValid && dec.ready;

  assign curImm = headIsImm ? head1[INSTR_W-1:0] : '0;
  assign curPc  = headIsImm ? head1[ENTRY_W-1:INSTR_W] + ADDR_W'(1)
                            : head0[ENTRY_W-1:INSTR_W] + ADDR_W'(1);

  fetch_word_fifo #(.WIDTH(ENTRY_W), .DEPTH(QDEPTH)) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (redirect),
    .push_i     (inflight_q),
    .pushData_i ({inflightAddr_q, imem.data}),
    .pop_i      (fire),
    .popTwo_i   (headIsImm),
    .head0_o    (head0),
    .head1_o    (head1),
    .count_o    (count)
  );

  // A second edge while one is still pending merges into it.
  always_comb begin
    pc_d         = redirect ? redirectTarget : (fetchOk ? pc_q + ADDR_W'(1) : pc_q);
    intPending_d = (intPending_q && (cause != INT)) || (interrupt_i && !intPrev_q && !intPending_q);
    intFlag_d    = intFlag_q;
    if (cause == INT)          intFlag_d = 1'b1;
    else if (redirect || fire) intFlag_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    intPrev_q <= interrupt_i;
    if (reset_i) begin
      pc_q           <= ADDR_W'(RESET_VEC);
      inflight_q     <= 1'b0;
      inflightAddr_q <= '0;
      intPending_q   <= 1'b0;
      intFlag_q      <= 1'b0;
      heldInstr_q    <= '0;
      heldImm_q      <= '0;
      heldPc_q       <= '0;
      heldHasImm_q   <= 1'b0;
      heldInt_q      <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      inflight_q     <= fetchOk;
      inflightAddr_q <= pc_q;
      intPending_q   <= intPending_d;
      intFlag_q      <= intFlag_d;
      if (decValid) begin
        heldInstr_q  <= head0[INSTR_W-1:0];
        heldImm_q    <= curImm;
        heldPc_q     <= curPc;
        heldHasImm_q <= headIsImm;
        heldInt_q    <= intFlag_q;
      end
    end
  end

  // Outside a valid cycle the decode fields keep showing the last presented instruction.
  assign dec.valid  = decValid;
  assign dec.instr  = decValid ? head0[INSTR_W-1:0] : heldInstr_q;
  assign dec.imm    = decValid ? curImm             : heldImm_q;
  assign dec.hasImm = decValid ? headIsImm          : heldHasImm_q;
  assign dec.pc     = decValid ? curPc              : heldPc_q;
  assign dec.isInt  = decValid ? intFlag_q          : heldInt_q;

  assign imem.rd    = fetchOk;
  assign imem.addr  = pc_q;
  assign q_count_o  = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected decode transfers are queued as stimulus is driven.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        hasImm;
    logic [31:0] pc;
    logic        isInt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, interrupt, exception, popPc, jmpSgn, popPc8;
  logic [31:0] popVal, jmpVal;
  logic [7:0]  popVal8;
  logic [2:0]  qCount, qCount8;
  logic [15:0] memArr [256];
  exp_t        sbQ [$];
  exp_t        obs, expv;
  int          checks = 0;
  int          failures = 0;
  int          xferCount = 0;
  int          base;

  always #5 clk = ~clk;

  fetch_imem_if #(.ADDR_W(32), .INSTR_W(16)) imemBus ();
  fetch_dec_if  #(.ADDR_W(32), .INSTR_W(16)) decBus ();
  fetch_imem_if #(.ADDR_W(8),  .INSTR_W(16)) imemBus8 ();
  fetch_dec_if  #(.ADDR_W(8),  .INSTR_W(16)) decBus8 ();

  fetch_unit dut (
    .clk_i(clk), .reset_i(reset), .imem(imemBus), .interrupt_i(interrupt),
    .exception_i(exception), .pop_pc_i(popPc), .pc_pop_value_i(popVal),
    .jmp_sgn_i(jmpSgn), .pc_jmp_value_i(jmpVal), .dec(decBus), .q_count_o(qCount)
  );

  fetch_unit #(.ADDR_W(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .imem(imemBus8), .interrupt_i(1'b0),
    .exception_i(1'b0), .pop_pc_i(popPc8), .pc_pop_value_i(popVal8),
    .jmp_sgn_i(1'b0), .pc_jmp_value_i(8'h00), .dec(decBus8), .q_count_o(qCount8)
  );

  // Instruction memory: data valid the cycle after a request.
  always @(posedge clk) begin
    imemBus.data  <= imemBus.rd  ? memArr[imemBus.addr[7:0]] : 16'hBEEF;
    imemBus8.data <= imemBus8.rd ? memArr[imemBus8.addr]     : 16'hBEEF;
  end

  // Every decode transfer is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && decBus.valid && decBus.ready) begin
      obs = '{decBus.instr, decBus.imm, decBus.hasImm, decBus.pc, decBus.isInt};
      checks++;
      if (sbQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL xfer_unexpected: got instr=%h pc=%h, required no transfer", obs.instr, obs.pc);
      end else begin
        expv = sbQ.pop_front();
        if (obs !== expv) begin
          failures++;
          $display("[TB] FAIL xfer: got instr=%h imm=%h has=%b pc=%h int=%b, required instr=%h imm=%h has=%b pc=%h int=%b",
                   obs.instr, obs.imm, obs.hasImm, obs.pc, obs.isInt,
                   expv.instr, expv.imm, expv.hasImm, expv.pc, expv.isInt);
        end
      end
      xferCount++;
    end
  end

  function automatic exp_t expectAt(input logic [31:0] addr, input logic isInt);
    exp_t e;
    logic [7:0] nxt;
    nxt     = addr[7:0] + 8'd1;
    e.instr = memArr[addr[7:0]];
    e.isInt = isInt;
    if (e.instr[15:12] == 4'h8) begin
      e.imm = memArr[nxt]; e.hasImm = 1'b1; e.pc = addr + 32'd2;
    end else begin
      e.imm = 16'h0; e.hasImm = 1'b0; e.pc = addr + 32'd1;
    end
    return e;
  endfunction

  // Leaves the bench in cycle 0 after reset release with all redirects idle.
  task applyReset();
    @(posedge clk); #1;
    reset = 1; interrupt = 0; exception = 0; popPc = 0; jmpSgn = 0; popPc8 = 0;
    decBus.ready = 0; decBus8.ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    sbQ.delete();
  endtask

  task test_reset();
    @(posedge clk); #1;
    reset = 1; popPc = 1; popVal = 32'h70; jmpSgn = 1; jmpVal = 32'h50; decBus.ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (imemBus.rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd: got %b, required 0", imemBus.rd); end
    checks++; if (decBus.valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, required 0", decBus.valid); end
    checks++; if (qCount !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d, required 0", qCount); end
    checks++; if ({decBus.instr, decBus.imm, decBus.pc} !== 64'h0) begin
      failures++; $display("[TB] FAIL reset_dec: got %h/%h/%h, required 0", decBus.instr, decBus.imm, decBus.pc); end
    @(posedge clk); #1;
    reset = 0; popPc = 0; jmpSgn = 0; decBus.ready = 0;
    @(negedge clk);
    checks++; if (imemBus.rd !== 1'b1) begin failures++; $display("[TB] FAIL reset_first_rd: got %b, required 1", imemBus.rd); end
    checks++; if (imemBus.addr !== 32'd32) begin failures++; $display("[TB] FAIL reset_first_addr: got %h, required 20", imemBus.addr); end
  endtask

  task test_basic();
    applyReset();
    base = xferCount;
    sbQ.push_back('{16'h1000, 16'h0, 1'b0, 32'd33, 1'b0});
    sbQ.push_back('{16'h2000, 16'h0, 1'b0, 32'd34, 1'b0});
    decBus.ready = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (decBus.valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_c1_valid: got %b, required 0", decBus.valid); end
    @(negedge clk);
    checks++; if ({decBus.valid, decBus.instr, decBus.pc} !== {1'b1, 16'h1000, 32'd33}) begin
      failures++; $display("[TB] FAIL basic_c2: got valid=%b instr=%h pc=%h, required 1/1000/21", decBus.valid, decBus.instr, decBus.pc); end
    for (int c = 0; c < 40 && xferCount < base + 2; c++) begin @(posedge clk); #1; end
    decBus.ready = 0;
    checks++; if (xferCount != base + 2 || sbQ.size() != 0) begin
      failures++; $display("[TB] FAIL basic_drain: got %0d transfers %0d pending, required 2 and 0", xferCount - base, sbQ.size()); end
  endtask

  task test_imm();
    applyReset();
    base = xferCount;
    popPc = 1; popVal = 32'd40; decBus.ready = 1;
    sbQ.push_back('{16'h8005, 16'h8123, 1'b1, 32'd42, 1'b0});
    sbQ.push_back(expectAt(32'd42, 1'b0));
    @(negedge clk);
    checks++; if ({decBus.valid, imemBus.rd} !== 2'b00) begin
      failures++; $display("[TB] FAIL imm_redirect_cycle: got valid=%b rd=%b, required 0/0", decBus.valid, imemBus.rd); end
    @(posedge clk); #1 popPc = 0;
    repeat (3) @(negedge clk);
    checks++; if ({decBus.valid, qCount} !== {1'b0, 3'd1}) begin
      failures++; $display("[TB] FAIL imm_half: got valid=%b count=%0d, required 0 and 1", decBus.valid, qCount); end
    for (int c = 0; c < 40 && xferCount < base + 2; c++) begin @(posedge clk); #1; end
    decBus.ready = 0;
    checks++; if (xferCount != base + 2 || sbQ.size() != 0) begin
      failures++; $display("[TB] FAIL imm_drain: got %0d transfers %0d pending, required 2 and 0", xferCount - base, sbQ.size()); end
  endtask

  task test_backpressure();
    logic [2:0] maxQ;
    applyReset();
    base = xferCount;
    maxQ = 0;
    repeat (10) begin @(negedge clk); if (qCount > maxQ) maxQ = qCount; end
    checks++; if (maxQ !== 3'd4) begin failures++; $display("[TB] FAIL bp_max_count: got %0d, required 4", maxQ); end
    checks++; if (qCount !== 3'd4) begin failures++; $display("[TB] FAIL bp_count: got %0d, required 4", qCount); end
    checks++; if (imemBus.rd !== 1'b0) begin failures++; $display("[TB] FAIL bp_rd: got %b, required 0", imemBus.rd); end
    for (int k = 0; k < 2; k++) begin
      checks++; if ({decBus.valid, decBus.instr, decBus.pc} !== {1'b1, 16'h1000, 32'd33}) begin
        failures++; $display("[TB] FAIL bp_stable: got valid=%b instr=%h pc=%h, required 1/1000/21", decBus.valid, decBus.instr, decBus.pc); end
      @(negedge clk);
    end
    for (int a = 32; a < 38; a++) sbQ.push_back(expectAt(32'(a), 1'b0));
    @(posedge clk); #1 decBus.ready = 1;
    for (int c = 0; c < 40 && xferCount < base + 6; c++) begin @(posedge clk); #1; end
    decBus.ready = 0;
    checks++; if (xferCount != base + 6 || sbQ.size() != 0) begin
      failures++; $display("[TB] FAIL bp_drain: got %0d transfers %0d pending, required 6 and 0", xferCount - base, sbQ.size()); end
  endtask

  task test_redirect_priority();
    applyReset();
    base = xferCount;
    repeat (2) begin @(posedge clk); #1; end
    popPc = 1; popVal = 32'h70; jmpSgn = 1; jmpVal = 32'h50;
    @(negedge clk);
    checks++; if ({decBus.valid, imemBus.rd} !== 2'b00) begin
      failures++; $display("[TB] FAIL redir_cycle: got valid=%b rd=%b, required 0/0", decBus.valid, imemBus.rd); end
    @(posedge clk); #1 popPc = 0; jmpSgn = 0;
    @(negedge clk);
    checks++; if ({imemBus.rd, imemBus.addr} !== {1'b1, 32'h70}) begin
      failures++; $display("[TB] FAIL redir_addr: got rd=%b addr=%h, required 1/70", imemBus.rd, imemBus.addr); end
    checks++; if (qCount !== 3'd0) begin failures++; $display("[TB] FAIL redir_flush: got %0d, required 0", qCount); end
    sbQ.push_back(expectAt(32'h70, 1'b0));
    sbQ.push_back(expectAt(32'h71, 1'b0));
    decBus.ready = 1;
    for (int c = 0; c < 40 && xferCount < base + 2; c++) begin @(posedge clk); #1; end
    decBus.ready = 0;
    checks++; if (xferCount != base + 2 || sbQ.size() != 0) begin
      failures++; $display("[TB] FAIL redir_drain: got %0d transfers %0d pending, required 2 and 0", xferCount - base, sbQ.size()); end
  endtask

  task test_interrupt();
    applyReset();
    base = xferCount;
    repeat (2) begin @(posedge clk); #1; end
    interrupt = 1; exception = 1;
    @(negedge clk);
    checks++; if ({decBus.valid, imemBus.rd} !== 2'b00) begin
      failures++; $display("[TB] FAIL int_exc_cycle: got valid=%b rd=%b, required 0/0", decBus.valid, imemBus.rd); end
    @(posedge clk); #1 exception = 0;
    @(negedge clk);
    checks++; if ({imemBus.rd, imemBus.addr} !== {1'b0, 32'd32}) begin
      failures++; $display("[TB] FAIL int_take_cycle: got rd=%b addr=%h, required 0/20", imemBus.rd, imemBus.addr); end
    @(posedge clk); #1;
    sbQ.push_back(expectAt(32'd0, 1'b1));
    sbQ.push_back(expectAt(32'd1, 1'b0));
    decBus.ready = 1;
    @(negedge clk);
    checks++; if ({imemBus.rd, imemBus.addr} !== {1'b1, 32'd0}) begin
      failures++; $display("[TB] FAIL int_vec_addr: got rd=%b addr=%h, required 1/0", imemBus.rd, imemBus.addr); end
    for (int c = 0; c < 40 && xferCount < base + 2; c++) begin @(posedge clk); #1; end
    decBus.ready = 0;
    checks++; if (xferCount != base + 2 || sbQ.size() != 0) begin
      failures++; $display("[TB] FAIL int_drain: got %0d transfers %0d pending, required 2 and 0", xferCount - base, sbQ.size()); end
    // Second interrupt is redirected away before any transfer, so its flag is lost.
    base = xferCount;
    @(posedge clk); #1 interrupt = 0;
    @(posedge clk); #1 interrupt = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 jmpSgn = 1; jmpVal = 32'h60;
    @(posedge clk); #1 jmpSgn = 0;
    sbQ.push_back(expectAt(32'h60, 1'b0));
    sbQ.push_back(expectAt(32'h61, 1'b0));
    decBus.ready = 1;
    for (int c = 0; c < 40 && xferCount < base + 2; c++) begin @(posedge clk); #1; end
    decBus.ready = 0;
    checks++; if (xferCount != base + 2 || sbQ.size() != 0) begin
      failures++; $display("[TB] FAIL int_cancel_drain: got %0d transfers %0d pending, required 2 and 0", xferCount - base, sbQ.size()); end
  endtask

  task test_wrap();
    applyReset();
    popPc8 = 1; popVal8 = 8'hFF; decBus8.ready = 1;
    @(posedge clk); #1 popPc8 = 0;
    @(negedge clk);
    checks++; if ({imemBus8.rd, imemBus8.addr} !== {1'b1, 8'hFF}) begin
      failures++; $display("[TB] FAIL wrap_addr_ff: got rd=%b addr=%h, required 1/ff", imemBus8.rd, imemBus8.addr); end
    @(negedge clk);
    checks++; if (imemBus8.addr !== 8'h00) begin failures++; $display("[TB] FAIL wrap_addr_00: got %h, required 00", imemBus8.addr); end
    for (int c = 0; c < 10 && decBus8.valid !== 1'b1; c++) @(negedge clk);
    checks++; if ({decBus8.valid, decBus8.instr, decBus8.pc} !== {1'b1, 16'h30FF, 8'h00}) begin
      failures++; $display("[TB] FAIL wrap_dec_pc: got valid=%b instr=%h pc=%h, required 1/30ff/00", decBus8.valid, decBus8.instr, decBus8.pc); end
    decBus8.ready = 0;
  endtask

  initial begin
    reset = 1; interrupt = 0; exception = 0; popPc = 0; jmpSgn = 0; popPc8 = 0;
    popVal = 0; jmpVal = 0; popVal8 = 0; decBus.ready = 0; decBus8.ready = 0;
    for (int i = 0; i < 256; i++) memArr[i] = {8'h30, 8'(i)};
    memArr[32] = 16'h1000;
    memArr[33] = 16'h2000;
    memArr[40] = 16'h8005;
    memArr[41] = 16'h8123;
    $display("[TB] starting fetch_unit bench");
    test_reset();
    test_basic();
    test_imm();
    test_backpressure();
    test_redirect_priority();
    test_interrupt();
    test_wrap();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, required completion before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Param ADDR_W, 32, PC/address width.
REQ-002 Param INSTR_W, 16, instruction word width.
REQ-003 Param QDEPTH, 4, word-queue depth, power of 2, >=2.
REQ-004 Param RESET_VEC, 32, PC loaded on reset or exception.
REQ-005 Param INT_VEC, 0, PC loaded when interrupt is taken.
REQ-006 Param IMM_OPCODE, 4'd8, opcode (word[INSTR_W-1:INSTR_W-4]) marking a two-word instruction.
REQ-007 clk  in  1  single clock, all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 imem_rd  out  1  instruction-memory read request.
REQ-010 imem_addr  out  ADDR_W  request address (= PC).
REQ-011 imem_data  in  INSTR_W  read data, valid the cycle after the request.
REQ-012 interrupt  in  1  external interrupt, rising-edge sensitive.
REQ-013 exception  in  1  exception redirect, level, one-cycle pulse.
REQ-014 pop_pc / pc_pop_value  in  1 / ADDR_W  return redirect and target.
REQ-015 jmp_sgn / pc_jmp_value  in  1 / ADDR_W  jump redirect and target.
REQ-016 dec_valid  out  1  instruction presented to decode.
REQ-017 dec_ready  in  1  decode accepts; transfer when dec_valid & dec_ready.
REQ-018 dec_instr / dec_imm  out  INSTR_W  first word / second word (0 if none).
REQ-019 dec_has_imm  out  1  instruction is two-word.
REQ-020 dec_pc  out  ADDR_W  address following the instruction (return address).
REQ-021 dec_int  out  1  instruction is the first one fetched from INT_VEC after an interrupt was taken.
REQ-022 q_count  out  $clog2(QDEPTH+1)  words currently queued.

Function
REQ-023 Redirect priority, highest first: exception (RESET_VEC), pending interrupt (INT_VEC), pop_pc, jmp_sgn; a redirect loads PC at the edge, empties the queue, and discards any in-flight response.
REQ-024 dec_valid SHALL be 0 in any cycle a redirect is asserted; no transfer occurs that cycle.
REQ-025 imem_rd SHALL be 1 iff no redirect and q_count + inflight < QDEPTH; each request increments PC by 1, modulo 2^ADDR_W.
REQ-026 Response to a request in cycle N is written to the queue at end of cycle N+1 with its address; earliest dec_valid is cycle N+2.
REQ-027 Head word with opcode != IMM_OPCODE: dec_valid when q_count>=1; transfer pops 1; dec_has_imm=0, dec_imm=0, dec_pc=addr+1.
REQ-028 Head word with opcode == IMM_OPCODE: dec_valid only when q_count>=2; dec_imm=second word, opcode of second word never inspected; transfer pops 2; dec_pc=addr+2.
REQ-029 Push and pop in the same cycle SHALL both take effect; queue never overflows or underflows.
REQ-030 Rising edge on interrupt sets int_pending; it is taken at the next cycle with no exception, then cleared; a second edge while pending is merged.
REQ-031 After an interrupt is taken, dec_int=1 on the first transfer only; a later redirect before that transfer cancels the flag.
REQ-032 Outputs during dec_valid=0 hold last value except dec_valid; dec_* SHALL be stable while dec_valid & !dec_ready.

Reset
REQ-033 On reset: PC=RESET_VEC, queue empty, inflight=0, int_pending=0, dec_int flag=0, dec_valid=0, imem_rd=0, q_count=0, dec_instr/dec_imm/dec_pc=0.
REQ-034 Reset overrides all redirects; first request (addr RESET_VEC) issues in the first cycle after reset deasserts.
REQ-035 Reset mid-fetch discards the in-flight response.

Structure
REQ-036 Package fetch_pkg holds default vector constants, IMM_OPCODE default and the redirect-cause enum (NONE, EXC, INT, POP, JMP).
REQ-037 Queue is sub-module fetch_word_fifo (params WIDTH, DEPTH; push/pop/flush, two-entry read port, count).

Verification
REQ-038 Reset, imem returns 0x1000,0x2000 at 32,33, dec_ready=1 -> dec_instr 0x1000 cycle 2 with dec_pc 33, then 0x2000 with dec_pc 34.
REQ-039 Words 0x8005,0x8123 at 40,41 -> single transfer, dec_has_imm=1, dec_imm=0x8123, dec_pc 42; 0x8123 not treated as opcode.
REQ-040 dec_ready=0 for 10 cycles -> q_count saturates at 4, imem_rd=0, no word lost after release.
REQ-041 jmp_sgn to 0x50 same cycle as pop_pc to 0x70 -> next imem_addr 0x70, queue flushed, stale response dropped.
REQ-042 interrupt edge with exception same cycle -> PC=32; interrupt taken next cycle, PC=0, first transfer has dec_int=1.
REQ-043 PC=2^ADDR_W-1 with ADDR_W=8 -> next request address 0, dec_pc wraps to 0.
